result_hex_display: RTL and testbench
=====================================

// Module: result_hex_display
// PURPOSE
//  Downstream of tiny_risc_v. Captures a 32-bit result word from the core, e.g. the ALU
//  result when done pulses, and drives a time-multiplexed seven-segment display.
//  Converts signed values to sign-magnitude. Scans hex digits one at a time.
//  Segment order is {a,b,c,d,e,f,g}, MSB = a, active-high.
// PARAMETERS
//  NUM_DIGITS  8  hex digits displayed; legal range 1..8; digit i shows magnitude bits [4i+3:4i]
//  SCAN_DIV    4  clock cycles each digit is held during a scan; legal range >=1
// PORTS
//  clk        in   1           system clock; all logic on rising edge
//  rst        in   1           synchronous reset, active-high
//  load       in   1           capture request; sampled only while ready=1
//  value      in   32          result word to display
//  signed_mode in  1           1: treat value as two's complement; sampled with load
//  ready      out  1           block can accept load
//  busy       out  1           conversion in progress (CONV state)
//  seg_digit  out  7           segment pattern of the selected hex digit
//  seg_neg    out  7           sign digit: 7'b0000001 = '-', 7'b0000000 = '+'
//  digit_sel  out  NUM_DIGITS  one-hot enable of the digit currently driven
//  overflow   out  1           magnitude has nonzero nibbles above digit NUM_DIGITS-1
// BEHAVIOUR
//  - Reset (rst=1 at edge):
//    - state=IDLE; seg_digit=0, seg_neg=0, digit_sel=0, overflow=0, busy=0, ready=1.
//    - Reset has priority over load and overrides any state.
//  - FSM states: IDLE, CONV, SCAN.
//    - ready = (state != CONV); busy = (state == CONV).
//  - IDLE:
//    - Outputs hold reset values.
//    - load=1 at edge N: value and signed_mode are registered, then go to CONV.
//  - CONV (exactly 1 cycle):
//    - If signed_mode=1 and value[31]=1: mag = ~value + 1 and neg=1.
//    - Otherwise: mag = value and neg=0.
//    - mag is a 32-bit unsigned value; 0x80000000 stays 0x80000000 with neg=1 and no error.
//    - Next state is SCAN. load during CONV is ignored and not queued.
//  - SCAN:
//    - Entered at edge N+2 with digit index 0: digit_sel = 1<<0, seg_digit = enc(mag[3:0]).
//    - Each digit is held for SCAN_DIV cycles, then the index advances.
//    - Index NUM_DIGITS-1 wraps to 0. The scan runs indefinitely.
//    - seg_neg = neg ? 7'b0000001 : 7'b0000000, held for the whole SCAN state.
//    - overflow = |(mag >> 4*NUM_DIGITS); 0 when NUM_DIGITS=8.
//    - load=1 in SCAN captures the new value, goes to CONV, and resets the index and
//      divider. Outputs clear to zero during CONV.
//  - Hex encoding enc():
//    - 0 = 1111110, 1 = 0110000, 2 = 1101101, 3 = 1111001
//    - 4 = 0110011, 5 = 1011011, 6 = 1011111, 7 = 1110000
//    - 8 = 1111111, 9 = 1111011, A = 1110111, B = 0011111
//    - C = 1001110, D = 0111101, E = 1001111, F = 1000111
//  - All outputs are registered. seg_digit changes on the same edge as digit_sel.
// CONFIGURATION
//  - BLANK_LEADING_EN defined:
//    - Digits above the most significant nonzero nibble of mag drive seg_digit = 7'b0000000
//      while selected.
//    - Digit 0 is never blanked, so value 0 shows a single "0".
//    - The blank mask is computed in CONV.
//  - BLANK_LEADING_EN undefined:
//    - Every digit shows enc(nibble), including leading zeros (1111110).
// TESTING
//  1. Reset: rst=1 for 2 cycles, load=1 -> all outputs 0 and ready=1 at every edge;
//     no capture occurs.
//  2. Unsigned value 0x0000002A, load at edge N:
//     - busy=1 at N+1.
//     - At N+2: digit_sel=0x01, seg_digit=1110111.
//     - At N+2+SCAN_DIV: digit_sel=0x02, seg_digit=1101101.
//     - Digits 2..7 show 1111110; seg_neg=0000000; the index wraps to digit 0 after
//       8*SCAN_DIV cycles.
//  3. Signed values:
//     - 0xFFFFFFFF -> seg_neg=0000001; digit 0 = 0110000; others 1111110.
//     - 0x80000000 -> seg_neg=0000001; digit 7 = 1111111; others 1111110.
//  4. Load while busy or scanning:
//     - load held through CONV -> ignored; the value captured at N is displayed.
//     - A new load in mid-SCAN -> busy=1 for 1 cycle, then the scan restarts at
//       digit 0 with the new value.
//  5. Overflow: NUM_DIGITS=4, value 0x00012345 ->
//     - overflow=1.
//     - Digits 0..3 show 5, 4, 3, 2 (1011011, 0110011, 1111001, 1101101).
//     - Reloading 0x00001234 clears overflow.
//  6. With BLANK_LEADING_EN defined:
//     - 0x0000002A -> digits 2..7 drive 0000000.
//     - 0x00000000 -> digit 0 = 1111110, all other digits 0000000.

Source files
------------

// File: rtl/result_hex_display.sv
// Captures a 32-bit result word, converts it to sign-magnitude and scans it
// across a multiplexed seven-segment display. Optional macro: BLANK_LEADING_EN.
module result_hex_display #(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [31:0]           value,
    input  logic                  signed_mode,
    output logic                  ready,
    output logic                  busy,
    output logic [6:0]            seg_digit,
    output logic [6:0]            seg_neg,
    output logic [NUM_DIGITS-1:0] digit_sel,
    output logic                  overflow
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        SCAN = 2'd2
    } state_t;

    state_t                  state_reg, state_next;
    logic [31:0]             value_reg, value_next;
    logic                    signed_reg, signed_next;
    logic [31:0]             mag_reg, mag_next;
    logic                    neg_reg, neg_next;
    logic [NUM_DIGITS-1:0]   blank_reg, blank_next;
    logic [IDX_W-1:0]        idx_reg, idx_next;
    logic [DIV_W-1:0]        div_reg, div_next;
    logic [6:0]              seg_digit_reg, seg_digit_next;
    logic [6:0]              seg_neg_reg, seg_neg_next;
    logic [NUM_DIGITS-1:0]   digit_sel_reg, digit_sel_next;
    logic                    overflow_reg, overflow_next;

    logic                    conv_neg;
    logic [31:0]             conv_mag;
    logic                    conv_ovf;
    logic [NUM_DIGITS-1:0]   conv_blank;
    logic [3:0]              nib [NUM_DIGITS];
    logic [IDX_W-1:0]        idx_adv;
    logic [DIV_W-1:0]        div_adv;

    function automatic logic [6:0] enc(input logic [3:0] n);
        case (n)
            4'h0: enc = 7'b1111110;
            4'h1: enc = 7'b0110000;
            4'h2: enc = 7'b1101101;
            4'h3: enc = 7'b1111001;
            4'h4: enc = 7'b0110011;
            4'h5: enc = 7'b1011011;
            4'h6: enc = 7'b1011111;
            4'h7: enc = 7'b1110000;
            4'h8: enc = 7'b1111111;
            4'h9: enc = 7'b1111011;
            4'hA: enc = 7'b1110111;
            4'hB: enc = 7'b0011111;
            4'hC: enc = 7'b1001110;
            4'hD: enc = 7'b0111101;
            4'hE: enc = 7'b1001111;
            default: enc = 7'b1000111;
        endcase
    endfunction

    // 0x80000000 negates to itself, which is exactly the unsigned magnitude wanted.
    assign conv_neg = signed_reg & value_reg[31];
    assign conv_mag = conv_neg ? (~value_reg + 32'd1) : value_reg;
    assign conv_ovf = |(conv_mag >> (4 * NUM_DIGITS));

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign nib[gi] = mag_reg[4*gi +: 4];
`ifdef BLANK_LEADING_EN
            if (gi == 0) begin : g_keep
                assign conv_blank[gi] = 1'b0;
            end else begin : g_blank
                assign conv_blank[gi] = ((conv_mag >> (4 * gi)) == 32'd0);
            end
`else
            assign conv_blank[gi] = 1'b0;
`endif
        end
    endgenerate

    always_comb begin
        idx_adv = idx_reg;
        div_adv = div_reg + DIV_W'(1);
        if (div_reg == LAST_DIV) begin
            div_adv = '0;
            idx_adv = (idx_reg == LAST_IDX) ? '0 : idx_reg + IDX_W'(1);
        end
    end

    always_comb begin
        state_next     = state_reg;
        value_next     = value_reg;
        signed_next    = signed_reg;
        mag_next       = mag_reg;
        neg_next       = neg_reg;
        blank_next     = blank_reg;
        idx_next       = idx_reg;
        div_next       = div_reg;
        seg_digit_next = seg_digit_reg;
        seg_neg_next   = seg_neg_reg;
        digit_sel_next = digit_sel_reg;
        overflow_next  = overflow_reg;

        case (state_reg)
            IDLE: begin
                seg_digit_next = '0;
                seg_neg_next   = '0;
                digit_sel_next = '0;
                overflow_next  = 1'b0;
                if (load) begin
                    value_next  = value;
                    signed_next = signed_mode;
                    state_next  = CONV;
                end
            end
            CONV: begin
                mag_next          = conv_mag;
                neg_next          = conv_neg;
                blank_next        = conv_blank;
                idx_next          = '0;
                div_next          = '0;
                digit_sel_next    = '0;
                digit_sel_next[0] = 1'b1;
                seg_digit_next    = enc(conv_mag[3:0]);
                seg_neg_next      = conv_neg ? 7'b0000001 : 7'b0000000;
                overflow_next     = conv_ovf;
                state_next        = SCAN;
            end
            SCAN: begin
                if (load) begin
                    value_next     = value;
                    signed_next    = signed_mode;
                    seg_digit_next = '0;
                    seg_neg_next   = '0;
                    digit_sel_next = '0;
                    overflow_next  = 1'b0;
                    state_next     = CONV;
                end else begin
                    idx_next                = idx_adv;
                    div_next                = div_adv;
                    digit_sel_next          = '0;
                    digit_sel_next[idx_adv] = 1'b1;
                    seg_digit_next          = blank_reg[idx_adv] ? 7'b0000000 : enc(nib[idx_adv]);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            value_reg     <= '0;
            signed_reg    <= 1'b0;
            mag_reg       <= '0;
            neg_reg       <= 1'b0;
            blank_reg     <= '0;
            idx_reg       <= '0;
            div_reg       <= '0;
            seg_digit_reg <= '0;
            seg_neg_reg   <= '0;
            digit_sel_reg <= '0;
            overflow_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            value_reg     <= value_next;
            signed_reg    <= signed_next;
            mag_reg       <= mag_next;
            neg_reg       <= neg_next;
            blank_reg     <= blank_next;
            idx_reg       <= idx_next;
            div_reg       <= div_next;
            seg_digit_reg <= seg_digit_next;
            seg_neg_reg   <= seg_neg_next;
            digit_sel_reg <= digit_sel_next;
            overflow_reg  <= overflow_next;
        end
    end

    assign ready     = (state_reg != CONV);
    assign busy      = (state_reg == CONV);
    assign seg_digit = seg_digit_reg;
    assign seg_neg   = seg_neg_reg;
    assign digit_sel = digit_sel_reg;
    assign overflow  = overflow_reg;

endmodule

// File: tb/tb_result_hex_display.sv
// Directed bench for result_hex_display: an 8-digit instance for scan/sign
// behaviour and a 4-digit instance for overflow.
module tb_result_hex_display;

    localparam int SCAN_DIV = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        load, signed_mode;
    logic [31:0] value;
    logic        ready, busy, overflow;
    logic [6:0]  seg_digit, seg_neg;
    logic [7:0]  digit_sel;

    logic        load4, signed4;
    logic [31:0] value4;
    logic        ready4, busy4, overflow4;
    logic [6:0]  seg_digit4, seg_neg4;
    logic [3:0]  digit_sel4;

    int n_checks = 0;
    int n_bad    = 0;

    logic [6:0] enc_tb [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    always #5 clk = ~clk;

    result_hex_display #(.NUM_DIGITS(8), .SCAN_DIV(SCAN_DIV)) u_dut (
        .clk(clk), .rst(rst), .load(load), .value(value), .signed_mode(signed_mode),
        .ready(ready), .busy(busy), .seg_digit(seg_digit), .seg_neg(seg_neg),
        .digit_sel(digit_sel), .overflow(overflow)
    );

    result_hex_display #(.NUM_DIGITS(4), .SCAN_DIV(SCAN_DIV)) u_dut4 (
        .clk(clk), .rst(rst), .load(load4), .value(value4), .signed_mode(signed4),
        .ready(ready4), .busy(busy4), .seg_digit(seg_digit4), .seg_neg(seg_neg4),
        .digit_sel(digit_sel4), .overflow(overflow4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] exp_seg(input logic [31:0] mag, input int d);
        logic [3:0] n;
        n = mag[4*d +: 4];
`ifdef BLANK_LEADING_EN
        if (d > 0 && (mag >> (4 * d)) == 32'd0) return 7'b0000000;
`endif
        return enc_tb[n];
    endfunction

    // Issues a one-cycle load, checks the CONV cycle, and leaves the bench
    // just after the edge that enters SCAN at digit 0.
    task automatic do_load(input logic [31:0] v, input logic s);
        $display("load value=%h signed=%0b", v, s);
        load = 1'b1; value = v; signed_mode = s;
        tick();
        load = 1'b0;
        check("conv_busy", {31'd0, busy}, 32'd1);
        check("conv_ready", {31'd0, ready}, 32'd0);
        check("conv_sel", {24'd0, digit_sel}, 32'd0);
        check("conv_seg", {25'd0, seg_digit}, 32'd0);
        tick();
        check("scan_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic scan_check(input logic [31:0] mag, input logic neg);
        for (int d = 0; d < 8; d++) begin
            check("sel", {24'd0, digit_sel}, 32'd1 << d);
            check("seg", {25'd0, seg_digit}, {25'd0, exp_seg(mag, d)});
            check("neg", {25'd0, seg_neg}, neg ? 32'd1 : 32'd0);
            check("ovf", {31'd0, overflow}, 32'd0);
            repeat (SCAN_DIV - 1) tick();
            check("hold", {24'd0, digit_sel}, 32'd1 << d);
            tick();
        end
        check("wrap_sel", {24'd0, digit_sel}, 32'd1);
        check("wrap_seg", {25'd0, seg_digit}, {25'd0, exp_seg(mag, 0)});
    endtask

    initial begin
        rst = 1'b1; load = 1'b1; value = 32'h0000_1234; signed_mode = 1'b0;
        load4 = 1'b0; value4 = '0; signed4 = 1'b0;

        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_ready", {31'd0, ready}, 32'd1);
            check("rst_busy", {31'd0, busy}, 32'd0);
            check("rst_sel", {24'd0, digit_sel}, 32'd0);
            check("rst_seg", {25'd0, seg_digit}, 32'd0);
            check("rst_neg", {25'd0, seg_neg}, 32'd0);
            check("rst_ovf", {31'd0, overflow}, 32'd0);
        end
        rst = 1'b0; load = 1'b0;
        tick();
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_sel", {24'd0, digit_sel}, 32'd0);

        do_load(32'h0000_002A, 1'b0);
        scan_check(32'h0000_002A, 1'b0);

        do_load(32'hFFFF_FFFF, 1'b1);
        scan_check(32'h0000_0001, 1'b1);

        do_load(32'h8000_0000, 1'b1);
        scan_check(32'h8000_0000, 1'b1);

        do_load(32'hFFFF_FFFF, 1'b0);
        scan_check(32'hFFFF_FFFF, 1'b0);

        do_load(32'hFFFF_FFD6, 1'b1);
        scan_check(32'h0000_002A, 1'b1);

        do_load(32'h1234_5678, 1'b1);
        scan_check(32'h1234_5678, 1'b0);

        // Load held into CONV with a different value: the second value is dropped.
        $display("load value=00000013 held through conv");
        load = 1'b1; value = 32'h0000_0013; signed_mode = 1'b0;
        tick();
        value = 32'h0000_0099;
        check("held_busy", {31'd0, busy}, 32'd1);
        tick();
        load = 1'b0;
        check("held_sel", {24'd0, digit_sel}, 32'd1);
        check("held_seg", {25'd0, seg_digit}, 32'b1111001);
        tick();
        check("held_busy2", {31'd0, busy}, 32'd0);
        check("held_seg2", {25'd0, seg_digit}, 32'b1111001);

        // Mid-scan reload restarts at digit 0 with the new value.
        repeat (6) tick();
        check("mid_sel", {24'd0, digit_sel}, 32'd2);
        do_load(32'h0000_0005, 1'b0);
        scan_check(32'h0000_0005, 1'b0);

        do_load(32'h0000_0000, 1'b0);
        scan_check(32'h0000_0000, 1'b0);

        // Four-digit instance: nibble 4 of 0x12345 lies beyond the display.
        $display("load4 value=00012345 signed=0");
        load4 = 1'b1; value4 = 32'h0001_2345;
        tick();
        load4 = 1'b0;
        check("d4_busy", {31'd0, busy4}, 32'd1);
        tick();
        check("d4_ovf", {31'd0, overflow4}, 32'd1);
        check("d4_seg0", {25'd0, seg_digit4}, 32'b1011011);
        repeat (SCAN_DIV) tick();
        check("d4_sel1", {28'd0, digit_sel4}, 32'd2);
        check("d4_seg1", {25'd0, seg_digit4}, 32'b0110011);
        repeat (SCAN_DIV) tick();
        check("d4_seg2", {25'd0, seg_digit4}, 32'b1111001);
        repeat (SCAN_DIV) tick();
        check("d4_sel3", {28'd0, digit_sel4}, 32'd8);
        check("d4_seg3", {25'd0, seg_digit4}, 32'b1101101);
        repeat (SCAN_DIV) tick();
        check("d4_wrap", {28'd0, digit_sel4}, 32'd1);

        $display("load4 value=00001234 signed=0");
        load4 = 1'b1; value4 = 32'h0000_1234;
        tick();
        load4 = 1'b0;
        check("d4_conv_ovf", {31'd0, overflow4}, 32'd0);
        tick();
        check("d4_ovf_clr", {31'd0, overflow4}, 32'd0);
        check("d4_seg0b", {25'd0, seg_digit4}, 32'b0110011);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
